// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode encodings, instruction field helpers
// and the fetch-stage state type.
package cpu_pkg;

  localparam int AW = 4;
  localparam int IW = 16;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] inst_opcode(input logic [IW-1:0] inst);
    return inst[15:12];
  endfunction

  function automatic logic [3:0] inst_target(input logic [IW-1:0] inst);
    return inst[11:8];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM read port, execute redirect and the IR handshake.
// IR handshake: a word transfers on every rising edge where ir_valid & ir_ready;
// while ir_valid & !ir_ready, ir and ir_pc are held stable.
interface fetch_unit_if #(
  parameter int AW = cpu_pkg::AW,
  parameter int IW = cpu_pkg::IW
);
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_inst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output rom_addr, ir, ir_pc, ir_valid,
    input  rom_inst, redirect_valid, redirect_pc, ir_ready
  );

  modport slave (
    input  rom_addr, ir, ir_pc, ir_valid,
    output rom_inst, redirect_valid, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-pc priority mux: redirect > folded jump > increment > hold.
module pc_next_sel #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] pc_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic          fold_i,
  input  logic [AW-1:0] fold_target_i,
  input  logic          inc_i,
  output logic [AW-1:0] pc_next_o
);
  import cpu_pkg::*;

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i)  pc_next_o = redirect_pc_i;
    else if (fold_i) pc_next_o = fold_target_i;
    else if (inc_i)  pc_next_o = pc_i + AW'(1);
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address from pc, folds unconditional
// jumps, and registers instructions into IR toward decode.
module fetch_unit #(
  parameter int         AW       = 4,
  parameter int         IW       = 16,
  parameter logic [3:0] OP_JMP   = 4'b1000,
  parameter bit         FOLD_JMP = 1'b1,
  parameter int         CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus,
  input  logic          start,
  input  logic          halt_req,
  input  logic          step_mode,
  input  logic          step,
  output logic          halted,
  output logic [CW-1:0] fetch_count,
  output logic [1:0]    dbg_state
);
  import cpu_pkg::*;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          redirect_eff, can_fetch, is_jmp, fold, load;
  logic [AW-1:0] jmp_target;

  // A redirect arriving in IDLE is ignored; otherwise it overrides any fetch.
  assign redirect_eff = bus.redirect_valid && (state_q != ST_IDLE);
  assign can_fetch    = (state_q == ST_RUN) && (!ir_valid_q || bus.ir_ready) &&
                        (!step_mode || step);
  assign is_jmp       = FOLD_JMP && (inst_opcode(bus.rom_inst) == OP_JMP);
  assign jmp_target   = AW'(inst_target(bus.rom_inst));
  assign fold         = can_fetch && !redirect_eff && is_jmp;
  assign load         = can_fetch && !redirect_eff && !is_jmp;

  pc_next_sel #(.AW(AW)) u_pc_next_sel (
    .pc_i          (pc_q),
    .redirect_i    (redirect_eff),
    .redirect_pc_i (bus.redirect_pc),
    .fold_i        (fold),
    .fold_target_i (jmp_target),
    .inc_i         (load),
    .pc_next_o     (pc_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (halt_req) state_d = ST_HALT;
               else if (start) state_d = ST_RUN;
      ST_RUN:  if (halt_req || (fold && (jmp_target == pc_q))) state_d = ST_HALT;
      ST_HALT: if (start && !halt_req) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    if (redirect_eff) begin
      ir_valid_d = 1'b0;
    end else if (load) begin
      ir_d       = bus.rom_inst;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
    end else if (fold) begin
      ir_valid_d = ir_valid_q && !bus.ir_ready;
    end else if (ir_valid_q && bus.ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign halted       = (state_q == ST_HALT);
  assign fetch_count  = cnt_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, halt_req, step_mode, step;
  logic          halted;
  logic [CW-1:0] fetch_count;
  logic [1:0]    dbg_state;
  logic [IW-1:0] rom [16];

  fetch_unit_if #(.AW(AW), .IW(IW)) bus ();

  assign bus.rom_inst = rom[bus.rom_addr];

  fetch_unit #(.AW(AW), .IW(IW), .OP_JMP(OP_JMP), .FOLD_JMP(1'b1), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .start       (start),
    .halt_req    (halt_req),
    .step_mode   (step_mode),
    .step        (step),
    .halted      (halted),
    .fetch_count (fetch_count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit saw_jmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = running, 2 = halted
  int            m_mode = 0;
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_irpc = '0;
  logic [IW-1:0] m_ir = '0;
  bit            m_v = 1'b0;
  int            m_cnt = 0;
  logic [AW+IW-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [IW-1:0] inst;
    bit redir, fetch, jmp;
    int nxt;
    if (!rst_n) begin
      m_mode = 0; m_pc = '0; m_irpc = '0; m_ir = '0; m_v = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else begin
      inst  = rom[m_pc];
      redir = bus.redirect_valid && (m_mode != 0);
      fetch = (m_mode == 1) && (!m_v || bus.ir_ready) && (!step_mode || step) && !redir;
      jmp   = (inst[15:12] == OP_JMP);
      nxt   = m_mode;
      if (halt_req) nxt = 2;
      else if (m_mode != 1 && start) nxt = 1;
      else if (fetch && jmp && inst[11:8] == m_pc) nxt = 2;
      if (redir) begin
        if (m_v && !bus.ir_ready) void'(exp_q.pop_front());
        m_v  = 1'b0;
        m_pc = bus.redirect_pc;
      end else if (fetch && jmp) begin
        m_v  = 1'b0;
        m_pc = inst[11:8];
      end else if (fetch) begin
        exp_q.push_back({m_pc, inst});
        m_ir = inst; m_irpc = m_pc; m_v = 1'b1;
        m_pc = m_pc + 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else if (m_v && bus.ir_ready) begin
        m_v = 1'b0;
      end
      m_mode = nxt;
    end
  end

  // Compare process: outputs every cycle, delivered words against the queue.
  always @(negedge clk) begin : compare
    logic [AW+IW-1:0] e;
    chk("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
    chk("ir_valid", 32'(bus.ir_valid), 32'(m_v));
    chk("ir", 32'(bus.ir), 32'(m_ir));
    chk("ir_pc", 32'(bus.ir_pc), 32'(m_irpc));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    if (bus.ir_valid && bus.ir[15:12] == OP_JMP) saw_jmp = 1'b1;
    if (rst_n && m_v && bus.ir_ready) begin
      if (exp_q.size() == 0) begin
        chk("deliver_queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("deliver", 32'({bus.ir_pc, bus.ir}), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_pc(input logic [AW-1:0] a, input int lim);
    int k;
    k = 0;
    while (!(bus.ir_valid && bus.ir_pc == a) && k < lim) begin
      cyc();
      k++;
    end
    chk("wait_valid_pc_timeout", 32'(k < lim), 32'd1);
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) rom[i] = 16'h2000 + 16'(i);
    rom[0]  = 16'h1201; rom[1]  = 16'hB401; rom[2] = 16'h2100; rom[3] = 16'hBE01;
    rom[4]  = 16'h3300; rom[5]  = 16'hFE00; rom[6] = 16'h8300;
    rom[10] = 16'hF200; rom[11] = 16'h8B00;
  endtask

  initial begin
    int c, k;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    bus.ir_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    load_program();
    repeat (2) cyc();
    chk("rst_ir", 32'(bus.ir), 32'h0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);

    // Reset/run and back-to-back delivery
    rst_n = 1'b1; start = 1'b1; bus.ir_ready = 1'b1;
    wait_valid_pc(4'd0, 6);
    chk("run_ir0", 32'(bus.ir), 32'h1201);
    cyc();
    chk("run_ir1", 32'(bus.ir), 32'hB401);
    chk("run_ir1_pc", 32'(bus.ir_pc), 32'h1);
    chk("run_count", 32'(fetch_count), 32'h2);

    // Jump fold: FE00@5 then BE01@3
    wait_valid_pc(4'd5, 10);
    chk("fold_ir5", 32'(bus.ir), 32'hFE00);
    cyc();
    k = 0;
    while (!bus.ir_valid && k < 5) begin cyc(); k++; end
    chk("fold_ir3", 32'(bus.ir), 32'hBE01);
    chk("fold_ir3_pc", 32'(bus.ir_pc), 32'h3);

    // Mid-operation reset, then backpressure
    rst_n = 1'b0;
    #1;
    chk("midrst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("midrst_count", 32'(fetch_count), 32'h0);
    cyc();
    rst_n = 1'b1;
    wait_valid_pc(4'd0, 6);
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_ir", 32'(bus.ir), 32'h1201);
      chk("bp_hold_pc", 32'(bus.rom_addr), 32'h1);
    end
    bus.ir_ready = 1'b1;
    cyc();
    chk("bp_next_ir", 32'(bus.ir), 32'hB401);
    chk("bp_next_pc", 32'(bus.ir_pc), 32'h1);

    // Redirect discards the fetch from pc 4
    k = 0;
    while (bus.rom_addr != 4'd4 && k < 10) begin cyc(); k++; end
    chk("redir_reach_pc4", 32'(bus.rom_addr), 32'h4);
    c = fetch_count;
    start = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 4'd10;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("redir_flush", 32'(bus.ir_valid), 32'h0);
    chk("redir_count", 32'(fetch_count), 32'(c));
    cyc();
    chk("redir_ir", 32'(bus.ir), 32'hF200);
    chk("redir_ir_pc", 32'(bus.ir_pc), 32'hA);
    chk("redir_count_inc", 32'(fetch_count), 32'(c + 1));

    // Self-loop jump at 11 halts
    cyc();
    chk("selfloop_halted", 32'(halted), 32'h1);
    chk("selfloop_pc", 32'(bus.rom_addr), 32'hB);
    repeat (3) cyc();
    chk("selfloop_count", 32'(fetch_count), 32'(c + 1));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("resume_running", 32'(halted), 32'h0);
    cyc();
    chk("rehalt", 32'(halted), 32'h1);

    // Single step: three loads, stalled step dropped
    bus.redirect_valid = 1'b1; bus.redirect_pc = 4'd0; step_mode = 1'b1;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("step_redir_halt", 32'(bus.rom_addr), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    chk("step_no_free_fetch", 32'(bus.rom_addr), 32'h0);
    c = fetch_count;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.ir_ready = 1'b0;
      step = 1'b1;
      cyc();
      step = 1'b0;
      repeat (3) cyc();
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (2) cyc();
    chk("step_count3", 32'(fetch_count), 32'(c + 3));
    chk("step_stall_ir", 32'(bus.ir), 32'h2100);
    chk("step_stall_valid", 32'(bus.ir_valid), 32'h1);
    bus.ir_ready = 1'b1;
    repeat (3) cyc();
    chk("step_drop_count", 32'(fetch_count), 32'(c + 3));
    chk("step_drop_pc", 32'(bus.rom_addr), 32'h3);

    // Randomized run against the model
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(0, 4) == 0) rom[i][15:12] = OP_JMP;
    end
    cyc();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) step_mode = ($urandom_range(0, 2) == 0);
      start              = ($urandom_range(0, 4) == 0);
      halt_req           = ($urandom_range(0, 40) == 0);
      step               = ($urandom_range(0, 2) == 0);
      bus.ir_ready       = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
    end
    chk("jmp_never_on_ir", 32'(saw_jmp), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
